// File: rtl/pp_loop_monitor.sv
// pp_loop_monitor: observes one pipelined loop's control signals; optional stall counter via PP_LOOP_MON_STALL_CNT_EN
module pp_loop_monitor #(
    parameter int FSM_WIDTH    = 2,
    parameter int CNT_WIDTH    = 32,
    parameter int MAX_INFLIGHT = 8,
    parameter int WDOG_LIMIT   = 1024
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [FSM_WIDTH-1:0]                  cur_state,
    input  logic                                  pre_states_valid,
    input  logic [FSM_WIDTH-1:0]                  pre_loop_state0,
    input  logic [2:0]                            post_states_valid,
    input  logic [FSM_WIDTH-1:0]                  post_loop_state0,
    input  logic [FSM_WIDTH-1:0]                  post_loop_state1,
    input  logic [FSM_WIDTH-1:0]                  post_loop_state2,
    input  logic [FSM_WIDTH-1:0]                  loop_quit_state,
    input  logic [FSM_WIDTH-1:0]                  iter_start_state,
    input  logic [FSM_WIDTH-1:0]                  iter_end_state,
    input  logic                                  iter_start_enable,
    input  logic                                  iter_start_block,
    input  logic                                  iter_end_enable,
    input  logic                                  iter_end_block,
    input  logic                                  quit_at_end,
    input  logic                                  finish,
    output logic [2:0]                            phase,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
    output logic [CNT_WIDTH-1:0]                  iter_started,
    output logic [CNT_WIDTH-1:0]                  iter_ended,
    output logic [CNT_WIDTH-1:0]                  stall_cycles,
    output logic                                  loop_done,
    output logic                                  err_underflow,
    output logic                                  err_overflow,
    output logic                                  err_watchdog
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, PRE, LOOP, DRAIN, POST, DONE} phase_t;

    phase_t          state, state_nxt;
    logic [WW-1:0]   wdog, wdog_nxt;
    logic [IW-1:0]   inflight_nxt;
    logic            start_evt, end_evt, quit_evt, post_hit, pre_hit;
    logic            inc, dec, over, under, idle;

    assign start_evt = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign end_evt   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign quit_evt  = cur_state == loop_quit_state;
    assign pre_hit   = pre_states_valid & (cur_state == pre_loop_state0);
    assign post_hit  = (post_states_valid[0] & (cur_state == post_loop_state0)) |
                       (post_states_valid[1] & (cur_state == post_loop_state1)) |
                       (post_states_valid[2] & (cur_state == post_loop_state2));

    // simultaneous start and end cancel, so only a lone event can move inflight
    assign inc          = start_evt & ~end_evt;
    assign dec          = end_evt & ~start_evt;
    assign over         = inc & (inflight == IW'(MAX_INFLIGHT));
    assign under        = dec & (inflight == '0);
    assign inflight_nxt = (inc & ~over)  ? inflight + 1'b1 :
                          (dec & ~under) ? inflight - 1'b1 : inflight;

    assign idle     = ((state == LOOP) | (state == DRAIN)) & ~start_evt & ~end_evt;
    assign wdog_nxt = !idle ? '0 : (wdog == WW'(WDOG_LIMIT)) ? wdog : wdog + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pre_hit ? PRE : start_evt ? LOOP : IDLE;
            PRE:     state_nxt = start_evt ? LOOP : PRE;
            LOOP:    state_nxt = !quit_evt ? LOOP : (quit_at_end & end_evt) ? POST : DRAIN;
            DRAIN:   state_nxt = (inflight_nxt == '0) ? POST : DRAIN;
            POST:    state_nxt = (finish | post_hit) ? DONE : POST;
            default: state_nxt = IDLE;
        endcase
        if (finish && state != DONE) state_nxt = DONE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            wdog          <= '0;
            inflight      <= '0;
            iter_started  <= '0;
            iter_ended    <= '0;
            loop_done     <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_watchdog  <= 1'b0;
        end else begin
            state         <= state_nxt;
            wdog          <= wdog_nxt;
            inflight      <= inflight_nxt;
            iter_started  <= iter_started + CNT_WIDTH'(start_evt & ~&iter_started);
            iter_ended    <= iter_ended + CNT_WIDTH'(end_evt & ~&iter_ended);
            loop_done     <= state_nxt == DONE;
            err_underflow <= err_underflow | under;
            err_overflow  <= err_overflow | over;
            err_watchdog  <= err_watchdog | (wdog_nxt == WW'(WDOG_LIMIT));
        end
    end

    assign phase = state;

`ifdef PP_LOOP_MON_STALL_CNT_EN
    logic stall_evt;
    assign stall_evt = ((cur_state == iter_start_state) & iter_start_enable & iter_start_block) |
                       ((cur_state == iter_end_state) & iter_end_enable & iter_end_block);
    always_ff @(posedge clock) begin
        if (!reset) stall_cycles <= '0;
        else        stall_cycles <= stall_cycles + CNT_WIDTH'(stall_evt & ~&stall_cycles);
    end
`else
    assign stall_cycles = '0;
`endif
endmodule
